// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uart_tx among N_REQ byte requesters.
// Optional WAIT-state watchdog is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          grant_o,
    output logic [N_REQ-1:0]          ack_o,
    output logic                      busy_o,
    output logic                      tx_start_o,
    output logic [DATA_W-1:0]         din_o,
    input  logic                      tx_done_i,
    output logic                      timeout_err_o
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : gen_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StStart, StWait, StAck} state_e;

    state_e                  state_q, state_d;
    logic [N_REQ-1:0]        grant_q, grant_d;
    logic [N_REQ-1:0]        ack_q, ack_d;
    logic                    tx_start_q, tx_start_d;
    logic [DATA_W-1:0]       din_q, din_d;
    logic [IdxW-1:0]         win_q, win_d;
    logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;

    logic [DATA_W-1:0]       req_bytes [N_REQ];
    logic [IdxW-1:0]         cand;
    logic [IdxW-1:0]         win_idx;
    logic                    win_found;

    for (genvar g = 0; g < N_REQ; g++) begin : gen_bytes
        assign req_bytes[g] = req_data_i[g*DATA_W +: DATA_W];
    end

    // First set request searching upward from rr_ptr_q, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = IdxW'((int'(rr_ptr_q) + k) % int'(N_REQ));
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            terr_q, terr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err_o = terr_q;
`else
    assign timeout_err_o = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        din_d      = din_q;
        win_d      = win_q;
        rr_ptr_d   = rr_ptr_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        terr_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d          = StStart;
                    win_d            = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    din_d            = req_bytes[win_idx];
                end
            end
            StStart: begin
                tx_start_d = 1'b1;
                state_d    = StWait;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            StWait: begin
                // A coincident tx_done wins over the watchdog.
                if (tx_done_i) begin
                    ack_d   = grant_q;
                    state_d = StAck;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    ack_d   = grant_q;
                    terr_d  = 1'b1;
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StAck: begin
                grant_d  = '0;
                rr_ptr_d = (win_q == IdxW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            din_q      <= '0;
            win_q      <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            din_q      <= din_d;
            win_q      <= win_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign grant_o    = grant_q;
    assign ack_o      = ack_q;
    assign busy_o     = (state_q != StIdle);
    assign tx_start_o = tx_start_q;
    assign din_o      = din_q;

endmodule
